pipe_stage_skid: RTL



---
 rtl/pipe_stage_skid.sv | 91 +++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage with 2-entry skid buffer; PIPE_STALL_CNT_EN adds stall_cnt
module pipe_stage_skid #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 2,
  parameter int TAG_W = 11,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [1:0]        occupancy
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE = 2'd1;
  localparam logic [1:0] TWO = 2'd2;
  logic [1:0] state, next_state;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [TAG_W-1:0] main_tag, skid_tag;
  logic accept, deliver, load_main, load_skid, pop_skid;
  assign in_ready = state != TWO;
  assign out_valid = state != EMPTY;
  assign occupancy = state;
  assign out_ctrl = out_valid ? main_ctrl : '0;
  assign out_data = main_data;
  assign out_tag = main_tag;
  assign accept = in_valid & in_ready & ~flush;
  assign deliver = out_valid & out_ready;
  // a new entry goes straight to the head unless the head is still waiting to leave
  assign load_main = accept & (~out_valid | deliver);
  assign load_skid = accept & out_valid & ~deliver;
  assign pop_skid = ~flush & (state == TWO) & deliver;
  always_comb begin
    next_state = flush ? EMPTY :
                 load_skid ? TWO :
                 load_main ? ONE :
                 deliver ? ((state == TWO) ? ONE : EMPTY) : state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      main_tag <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
      skid_tag <= '0;
    end else begin
      state <= next_state;
      if (flush) begin
        main_ctrl <= '0;
        skid_ctrl <= '0;
      end else begin
        if (load_main) begin
          main_ctrl <= in_ctrl;
          main_data <= in_data;
          main_tag <= in_tag;
        end else if (pop_skid) begin
          main_ctrl <= skid_ctrl;
          main_data <= skid_data;
          main_tag <= skid_tag;
        end
        if (load_skid) begin
          skid_ctrl <= in_ctrl;
          skid_data <= in_data;
          skid_tag <= in_tag;
        end
      end
    end
  end
`ifdef PIPE_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt <= '0;
    else if (out_valid & ~out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule
